// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
// Pure wiring, no latency of its own.
// No backpressure: start is a one-shot request, done is a one-cycle strobe.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  // Adder side: consumes operands, produces status and result
  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full-adder cell reused LSB-first across WIDTH bits.
// Latency: done rises WIDTH+1 cycles after the start cycle; one add per WIDTH+2 cycles.
// No backpressure: start is only sampled in IDLE and is dropped (not queued) otherwise.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  // Counter reaches WIDTH-1 as its last RUN value, so one extra bit over
  // the log covers every legal WIDTH including 1 and powers of two.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_next;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_s;
  logic             ha1_c;
  logic             fa_c;

  // Full-adder cell on the current LSBs: two half adders with the carries ORed
  always_comb begin
    ha0_s = ra[0] ^ rb[0];
    ha0_c = ra[0] & rb[0];
    ha1_s = ha0_s ^ c;
    ha1_c = ha0_s & c;
    fa_c  = ha0_c | ha1_c;
  end

  // Partial sum fills from the top so after WIDTH shifts bit 0 sits at bit 0
  if (WIDTH == 1) begin : g_ps_w1
    assign ps_next = ha1_s;
  end else begin : g_ps_wn
    assign ps_next = {ha1_s, ps[WIDTH-1:1]};
  end

  // Controller FSM and datapath registers; busy/done/sum/cout are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ra     <= '0;
      rb     <= '0;
      ps     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ra     <= bus.a;
            rb     <= bus.b;
            ps     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          c   <= fa_c;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          ps  <= ps_next;
          cnt <= cnt + CW'(1);
          // Result registers only move here, so they hold the old answer during RUN
          if (cnt == LAST) begin
            sum_q  <= ps_next;
            cout_q <= fa_c;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for the bit-serial adder controller.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Every wait on the DUT is bounded; a missed done shows up as a latency mismatch.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch n cycles in which neither busy nor done may appear
  task automatic quiet(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.busy || bus.done) hits++;
      tick();
    end
    chk({tag, "_quiet"}, hits, 0);
  endtask

  // mode 0: plain add; 1: spurious start (a=1,b=1) during RUN cycle 3;
  // 2: operands scrambled every RUN cycle after capture
  task automatic run_add(input string tag, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input int mode,
                         input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int cyc;
    int busy_n;
    int hold_bad;
    logic [WIDTH-1:0] prev;
    prev      = bus.sum;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc      = 0;
    busy_n   = 0;
    hold_bad = 0;
    while (!bus.done && cyc < 4 * WIDTH) begin
      if (bus.busy) busy_n++;
      if (bus.sum !== prev) hold_bad++;
      if (mode == 1 && cyc == 2) begin
        bus.start = 1'b1;
        bus.a     = 1;
        bus.b     = 1;
      end else begin
        bus.start = 1'b0;
      end
      if (mode == 2) begin
        bus.a = WIDTH'(cyc * 37 + 11);
        bus.b = ~bus.a;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    // Edges after the start edge until done is visible: E1..E_WIDTH
    chk({tag, "_lat"}, cyc, WIDTH);
    chk({tag, "_busy_cycles"}, busy_n, WIDTH);
    chk({tag, "_sum_held"}, hold_bad, 0);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_sum"}, bus.sum, exp_sum);
    chk({tag, "_cout"}, bus.cout, exp_cout);
    tick();
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum",  bus.sum,  0);
    chk("rst_cout", bus.cout, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic add and the carry/wrap corners
    run_add("add_3_5",     8'd3,   8'd5,   0, 8'd8,   1'b0);
    run_add("add_255_1",   8'd255, 8'd1,   0, 8'd0,   1'b1);
    run_add("add_255_255", 8'd255, 8'd255, 0, 8'd254, 1'b1);
    run_add("add_0_0",     8'd0,   8'd0,   0, 8'd0,   1'b0);
    tick();

    // Start during RUN must be dropped: one result, no follow-on busy period
    run_add("ign_start", 8'd10, 8'd20, 1, 8'd30, 1'b0);
    quiet("ign_start", 12);

    // Operand wiggling after capture must not leak into the result
    run_add("opnd_chg", 8'd100, 8'd27, 2, 8'd127, 1'b0);
    bus.a = '0;
    bus.b = '0;
    tick();

    // Abort mid-RUN: outputs clear asynchronously, no done afterwards
    bus.a     = 8'd200;
    bus.b     = 8'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pre_busy", bus.busy, 1);
    chk("abort_pre_sum",  bus.sum,  127);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_sum",  bus.sum,  0);
    chk("abort_cout", bus.cout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    quiet("abort", 12);
    run_add("post_abort", 8'd7, 8'd9, 0, 8'd16, 1'b0);
    tick();

    // Back-to-back: second start lands in the first IDLE cycle after done
    run_add("b2b_1", 8'd1,   8'd2,   0, 8'd3, 1'b0);
    run_add("b2b_2", 8'd128, 8'd128, 0, 8'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
